// File: rtl/conv3x3_stream.sv
// Streaming 3x3 convolution engine: two line buffers build a sliding window over
// a raster-order grayscale stream and emit Sobel X, Sobel Y, gradient magnitude
// or the window centre for every interior pixel, two cycles after the pixel
// that completes the window.
module conv3x3_stream #(
    parameter int DATA_W = 12,
    parameter int IMG_W  = 640,
    parameter int IMG_H  = 480,
    parameter int SHIFT  = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     sof,
    input  logic                     in_valid,
    input  logic [DATA_W-1:0]        in_pixel,
    input  logic [1:0]               mode,
    output logic                     out_valid,
    output logic [DATA_W-1:0]        out_pixel,
    output logic [$clog2(IMG_W)-1:0] out_x,
    output logic [$clog2(IMG_H)-1:0] out_y,
    output logic                     frame_done
);

    localparam int XW = $clog2(IMG_W);
    localparam int YW = $clog2(IMG_H);
    localparam int SW = DATA_W + 3;   // signed gradient width
    localparam int MW = DATA_W + 4;   // |Gx|+|Gy| width

    typedef enum logic [1:0] {ST_IDLE, ST_ACTIVE, ST_DONE} state_t;

    state_t          r_state, w_state_nxt;
    logic [XW-1:0]   r_col, w_col, w_col_nxt;
    logic [YW-1:0]   r_row, w_row, w_row_nxt;
    logic [1:0]      r_mode_q;
    logic            w_accept, w_last_col, w_last_row;
    logic [1:0]      w_mode_px;

    // A pixel is taken when it opens a frame or arrives while a frame is open;
    // a sof pixel is always position (0,0) regardless of the counters.
    assign w_accept   = in_valid && (sof || (r_state == ST_ACTIVE));
    assign w_col      = sof ? '0 : r_col;
    assign w_row      = sof ? '0 : r_row;
    assign w_last_col = (w_col == XW'(IMG_W - 1));
    assign w_last_row = (w_row == YW'(IMG_H - 1));
    assign w_mode_px  = sof ? mode : r_mode_q;

    // Frame state, raster counters and the per-frame mode.
    // NOTE: all clocked state uses non-blocking assignments so every register
    // samples pre-edge values; blocking here would create ordering-dependent logic.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_col    <= '0;
            r_row    <= '0;
            r_mode_q <= 2'd0;
        end else begin
            r_state <= w_state_nxt;
            r_col   <= w_col_nxt;
            r_row   <= w_row_nxt;
            if (w_accept && sof) r_mode_q <= mode;
        end
    end

    // Next-state and counter advance for each accepted pixel.
    // NOTE: every always_comb target gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_col_nxt   = r_col;
        w_row_nxt   = r_row;
        if (w_accept) begin
            w_state_nxt = ST_ACTIVE;
            w_col_nxt   = w_col + XW'(1);
            w_row_nxt   = w_row;
            if (w_last_col) begin
                w_col_nxt = '0;
                if (w_last_row) begin
                    w_row_nxt   = '0;
                    w_state_nxt = ST_DONE;
                end else begin
                    w_row_nxt = w_row + YW'(1);
                end
            end
        end
    end

    // Line buffers (r_lb_a = previous row, r_lb_b = two rows back) and the window.
    logic [DATA_W-1:0] r_lb_a [IMG_W];
    logic [DATA_W-1:0] r_lb_b [IMG_W];
    logic [DATA_W-1:0] r_win  [3][3];   // [row][col], row 0 is the oldest line

    // Shift a new column into the window and rotate the column through the buffers.
    // NOTE: line buffers and window carry no reset: their contents are only ever
    // consumed after being rewritten by the current frame, so clearing is wasted logic.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_lb_b[w_col] <= r_lb_a[w_col];
            r_lb_a[w_col] <= in_pixel;
            for (int i = 0; i < 3; i++) begin
                r_win[i][0] <= r_win[i][1];
                r_win[i][1] <= r_win[i][2];
            end
            r_win[0][2] <= r_lb_b[w_col];
            r_win[1][2] <= r_lb_a[w_col];
            r_win[2][2] <= in_pixel;
        end
    end

    // Stage 1: tag which accepted pixel completed an interior window.
    logic          r_s1_valid, r_s1_last;
    logic [XW-1:0] r_s1_x;
    logic [YW-1:0] r_s1_y;
    logic [1:0]    r_s1_mode;

    // Stage-1 control: centre coordinates and frame-end marker.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_last  <= 1'b0;
            r_s1_x     <= '0;
            r_s1_y     <= '0;
            r_s1_mode  <= 2'd0;
        end else begin
            r_s1_valid <= w_accept && (w_row >= YW'(2)) && (w_col >= XW'(2));
            r_s1_last  <= w_last_col && w_last_row;
            r_s1_x     <= w_col - XW'(1);
            r_s1_y     <= w_row - YW'(1);
            r_s1_mode  <= w_mode_px;
        end
    end

    // Sobel kernels on the registered window; all sums are non-negative before
    // the subtraction, so one extra sign bit suffices.
    logic [SW-1:0]        w_gx_pos, w_gx_neg, w_gy_pos, w_gy_neg;
    logic signed [SW-1:0] w_gx, w_gy;
    logic [SW-1:0]        w_ax, w_ay;

    assign w_gx_pos = SW'(r_win[0][2]) + (SW'(r_win[1][2]) << 1) + SW'(r_win[2][2]);
    assign w_gx_neg = SW'(r_win[0][0]) + (SW'(r_win[1][0]) << 1) + SW'(r_win[2][0]);
    assign w_gy_pos = SW'(r_win[2][0]) + (SW'(r_win[2][1]) << 1) + SW'(r_win[2][2]);
    assign w_gy_neg = SW'(r_win[0][0]) + (SW'(r_win[0][1]) << 1) + SW'(r_win[0][2]);
    assign w_gx     = $signed(w_gx_pos) - $signed(w_gx_neg);
    assign w_gy     = $signed(w_gy_pos) - $signed(w_gy_neg);
    assign w_ax     = w_gx[SW-1] ? SW'(-w_gx) : SW'(w_gx);
    assign w_ay     = w_gy[SW-1] ? SW'(-w_gy) : SW'(w_gy);

    // Stage 2: absolute gradients plus the untouched centre pixel.
    logic              r_s2_valid, r_s2_last;
    logic [SW-1:0]     r_s2_ax, r_s2_ay;
    logic [DATA_W-1:0] r_s2_ctr;
    logic [XW-1:0]     r_s2_x;
    logic [YW-1:0]     r_s2_y;
    logic [1:0]        r_s2_mode;

    // Stage-2 register: capture gradients computed from the stage-1 window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_s2_last  <= 1'b0;
            r_s2_ax    <= '0;
            r_s2_ay    <= '0;
            r_s2_ctr   <= '0;
            r_s2_x     <= '0;
            r_s2_y     <= '0;
            r_s2_mode  <= 2'd0;
        end else begin
            r_s2_valid <= r_s1_valid;
            r_s2_last  <= r_s1_valid && r_s1_last;
            r_s2_ax    <= w_ax;
            r_s2_ay    <= w_ay;
            r_s2_ctr   <= r_win[1][1];
            r_s2_x     <= r_s1_x;
            r_s2_y     <= r_s1_y;
            r_s2_mode  <= r_s1_mode;
        end
    end

    // Mode select, scale and clamp to the output pixel range.
    logic [MW-1:0]     w_sel, w_scaled;
    logic [DATA_W-1:0] w_sat, w_res;

    assign w_sel    = (r_s2_mode == 2'd0) ? MW'(r_s2_ax) :
                      (r_s2_mode == 2'd1) ? MW'(r_s2_ay) :
                      (MW'(r_s2_ax) + MW'(r_s2_ay));
    assign w_scaled = w_sel >> SHIFT;
    assign w_sat    = (|w_scaled[MW-1:DATA_W]) ? '1 : w_scaled[DATA_W-1:0];
    assign w_res    = (r_s2_mode == 2'd3) ? r_s2_ctr : w_sat;

    // Output register: payload only updates on a valid result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_pixel  <= '0;
            out_x      <= '0;
            out_y      <= '0;
            frame_done <= 1'b0;
        end else begin
            out_valid  <= r_s2_valid;
            frame_done <= r_s2_last;
            if (r_s2_valid) begin
                out_pixel <= w_res;
                out_x     <= r_s2_x;
                out_y     <= r_s2_y;
            end
        end
    end

endmodule

// File: tb/tb_conv3x3_stream.sv
// Self-checking bench for conv3x3_stream on a 6x4 image: table of frames with
// hand-computed per-column results, plus reset, ignore and restart sequences.
// A second instance with SHIFT=2 sees the same stimulus.
module tb_conv3x3_stream;

    localparam int DW = 12;
    localparam int IW = 6;
    localparam int IH = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          sof = 1'b0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_pixel = '0;
    logic [1:0]    mode = 2'd0;

    logic          out_valid_a, frame_done_a, out_valid_b, frame_done_b;
    logic [DW-1:0] out_pixel_a, out_pixel_b;
    logic [2:0]    out_x_a, out_x_b;
    logic [1:0]    out_y_a, out_y_b;

    conv3x3_stream #(.DATA_W(DW), .IMG_W(IW), .IMG_H(IH), .SHIFT(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .sof(sof), .in_valid(in_valid),
        .in_pixel(in_pixel), .mode(mode), .out_valid(out_valid_a),
        .out_pixel(out_pixel_a), .out_x(out_x_a), .out_y(out_y_a),
        .frame_done(frame_done_a)
    );

    conv3x3_stream #(.DATA_W(DW), .IMG_W(IW), .IMG_H(IH), .SHIFT(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .sof(sof), .in_valid(in_valid),
        .in_pixel(in_pixel), .mode(mode), .out_valid(out_valid_b),
        .out_pixel(out_pixel_b), .out_x(out_x_b), .out_y(out_y_b),
        .frame_done(frame_done_b)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // kind: 0 flat (lo), 1 vertical edge (cols 0-2 lo, 3-5 hi), 2 ramp 16*r+c
    typedef struct {
        int               kind;
        logic [DW-1:0]    lo, hi;
        logic [1:0]       mode_sof, mode_mid;
        bit               gaps;
        logic [3:0][11:0] exp;    // SHIFT=0 result for x=1..4
        logic [3:0][11:0] exp2;   // SHIFT=2 result for x=1..4
    } vec_t;

    typedef struct {
        logic [31:0] x, y, pix, pix2, done, v1, v2, cyc;
    } obs_t;

    typedef struct {
        int x, y, cyc;
    } exp_t;

    vec_t vecs[7];
    obs_t obs_q[$];
    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail = 0;

    always @(negedge clk) begin
        if (out_valid_a || out_valid_b)
            obs_q.push_back('{x: 32'(out_x_a), y: 32'(out_y_a), pix: 32'(out_pixel_a),
                              pix2: 32'(out_pixel_b), done: 32'(frame_done_a),
                              v1: 32'(out_valid_a), v2: 32'(out_valid_b), cyc: 32'(cyc)});
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    function automatic logic [DW-1:0] px_val(input int vi, input int r, input int c);
        case (vecs[vi].kind)
            0:       return vecs[vi].lo;
            1:       return (c < 3) ? vecs[vi].lo : vecs[vi].hi;
            default: return DW'(16 * r + c);
        endcase
    endfunction

    function automatic logic [DW-1:0] exp_pix(input int vi, input int x, input int y, input bit second);
        if (vecs[vi].kind == 2) return DW'(16 * y + x);
        return second ? vecs[vi].exp2[x-1] : vecs[vi].exp[x-1];
    endfunction

    task automatic drive_px(input logic s, input logic [DW-1:0] p, input logic [1:0] m,
                            input bit trig, input int r, input int c);
        @(negedge clk);
        sof      = s;
        in_valid = 1'b1;
        in_pixel = p;
        mode     = m;
        // accepted on the next edge (cyc+1), result visible two edges later
        if (trig) exp_q.push_back('{x: c - 1, y: r - 1, cyc: cyc + 3});
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            in_valid = 1'b0;
            sof      = 1'b0;
        end
    endtask

    task automatic send_pixels(input int vi, input int n_px);
        for (int i = 0; i < n_px; i++) begin
            int r, c;
            r = i / IW;
            c = i % IW;
            if (vecs[vi].gaps && ($urandom_range(0, 2) == 0)) idle(1);
            drive_px(i == 0, px_val(vi, r, c), (i == 0) ? vecs[vi].mode_sof : vecs[vi].mode_mid,
                     (r >= 2) && (c >= 2), r, c);
        end
    endtask

    task automatic check_frame(input int vi, input string tag);
        check({tag, " n_out"}, obs_q.size(), 8);
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            obs_t o;
            exp_t e;
            o = obs_q[i];
            e = exp_q[i];
            check($sformatf("%s[%0d] x", tag, i), o.x, e.x);
            check($sformatf("%s[%0d] y", tag, i), o.y, e.y);
            check($sformatf("%s[%0d] cycle", tag, i), o.cyc, e.cyc);
            check($sformatf("%s[%0d] pixel", tag, i), o.pix, 32'(exp_pix(vi, e.x, e.y, 1'b0)));
            check($sformatf("%s[%0d] pixel_shift2", tag, i), o.pix2, 32'(exp_pix(vi, e.x, e.y, 1'b1)));
            check($sformatf("%s[%0d] frame_done", tag, i), o.done, (i == 7) ? 32'd1 : 32'd0);
            check($sformatf("%s[%0d] valid", tag, i), o.v1, 32'd1);
            check($sformatf("%s[%0d] valid_shift2", tag, i), o.v2, 32'd1);
        end
    endtask

    task automatic run_frame(input int vi, input string tag);
        obs_q.delete();
        exp_q.delete();
        send_pixels(vi, IW * IH);
        idle(5);
        check_frame(vi, tag);
    endtask

    task automatic send_nosof(input int n);
        for (int i = 0; i < n; i++) drive_px(1'b0, DW'(12'h0FF + i), 2'd3, 1'b0, 0, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{kind: 0, lo: 12'h100, hi: 12'h100, mode_sof: 2'd0, mode_mid: 2'd0, gaps: 1'b0,
                    exp: 48'h0, exp2: 48'h0};
        vecs[1] = '{kind: 1, lo: 12'h000, hi: 12'h0FF, mode_sof: 2'd0, mode_mid: 2'd0, gaps: 1'b0,
                    exp: {12'h000, 12'h3FC, 12'h3FC, 12'h000}, exp2: {12'h000, 12'h0FF, 12'h0FF, 12'h000}};
        vecs[2] = '{kind: 1, lo: 12'h000, hi: 12'h0FF, mode_sof: 2'd1, mode_mid: 2'd1, gaps: 1'b0,
                    exp: 48'h0, exp2: 48'h0};
        vecs[3] = '{kind: 1, lo: 12'h000, hi: 12'hFFF, mode_sof: 2'd2, mode_mid: 2'd2, gaps: 1'b0,
                    exp: {12'h000, 12'hFFF, 12'hFFF, 12'h000}, exp2: {12'h000, 12'hFFF, 12'hFFF, 12'h000}};
        vecs[4] = '{kind: 1, lo: 12'h000, hi: 12'h0FF, mode_sof: 2'd0, mode_mid: 2'd0, gaps: 1'b1,
                    exp: {12'h000, 12'h3FC, 12'h3FC, 12'h000}, exp2: {12'h000, 12'h0FF, 12'h0FF, 12'h000}};
        vecs[5] = '{kind: 2, lo: 12'h000, hi: 12'h000, mode_sof: 2'd3, mode_mid: 2'd0, gaps: 1'b0,
                    exp: 48'h0, exp2: 48'h0};
        vecs[6] = '{kind: 1, lo: 12'h000, hi: 12'h0FF, mode_sof: 2'd2, mode_mid: 2'd1, gaps: 1'b0,
                    exp: {12'h000, 12'h3FC, 12'h3FC, 12'h000}, exp2: {12'h000, 12'h0FF, 12'h0FF, 12'h000}};

        // reset state
        repeat (3) @(negedge clk);
        check("reset out_valid", 32'(out_valid_a), 0);
        check("reset out_pixel", 32'(out_pixel_a), 0);
        check("reset out_x", 32'(out_x_a), 0);
        check("reset out_y", 32'(out_y_a), 0);
        check("reset frame_done", 32'(frame_done_a), 0);
        check("reset out_valid_shift2", 32'(out_valid_b), 0);
        rst_n = 1'b1;
        idle(2);

        for (int vi = 0; vi < 7; vi++) run_frame(vi, $sformatf("vec%0d", vi));

        // pixels after a completed frame without sof are dropped
        obs_q.delete();
        send_nosof(10);
        idle(5);
        check("done_ignore n_out", obs_q.size(), 0);

        // asynchronous reset while a result is on the outputs
        send_pixels(1, 16);   // up to (2,3): last result x=2,y=1 = 0x3FC
        idle(3);
        check("pre_reset out_valid", 32'(out_valid_a), 1);
        check("pre_reset out_pixel", 32'(out_pixel_a), 32'h3FC);
        check("pre_reset out_x", 32'(out_x_a), 2);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset out_valid", 32'(out_valid_a), 0);
        check("async_reset out_pixel", 32'(out_pixel_a), 0);
        check("async_reset out_x", 32'(out_x_a), 0);
        check("async_reset out_y", 32'(out_y_a), 0);
        check("async_reset frame_done", 32'(frame_done_a), 0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);

        // idle after reset: pixels without sof are dropped
        obs_q.delete();
        send_nosof(24);
        idle(5);
        check("idle_ignore n_out", obs_q.size(), 0);
        run_frame(1, "after_reset");

        // partial frame, then a fresh sof restarts the counters
        obs_q.delete();
        exp_q.delete();
        send_pixels(3, 20);   // through (3,1): one row of 4 results
        idle(5);
        check("partial n_out", obs_q.size(), 4);
        run_frame(5, "restart");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/conv3x3_stream.md
Name: conv3x3_stream

Overview:
Parametrised streaming 3x3 convolution engine, the generalised successor of the fixed Sobel stage in image_processing. Accepts one grayscale pixel per valid cycle in raster order, holds two line buffers, forms a 3x3 window and emits one filtered pixel per interior image position. Run-time mode selects Sobel X, Sobel Y, gradient magnitude or passthrough. Image size and pixel width are parameters. Sits between the Bayer-to-gray stage and the VGA/frame-buffer writer.

Parameters:
DATA_W, 12, pixel width in and out (unsigned)
IMG_W, 640, pixels per line (>=3)
IMG_H, 480, lines per frame (>=3)
SHIFT, 0, right shift applied to |Gx|, |Gy| and magnitude before saturation (0..3)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
sof  in  1  start of frame; valid only together with in_valid; marks pixel (0,0)
in_valid  in  1  in_pixel valid this cycle
in_pixel  in  DATA_W  input gray pixel
mode  in  2  0 = |Gx|, 1 = |Gy|, 2 = |Gx|+|Gy|, 3 = passthrough of window centre
out_valid  out  1  out_pixel/out_x/out_y valid
out_pixel  out  DATA_W  filtered pixel
out_x  out  $clog2(IMG_W)  column of window centre
out_y  out  $clog2(IMG_H)  row of window centre
frame_done  out  1  one-cycle pulse together with the last output of a frame

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous, active-low.
- Reset: out_valid=0, out_pixel=0, out_x=0, out_y=0, frame_done=0; column/row counters=0; frame state IDLE; line buffer contents need not be cleared.
- States: IDLE (ignore in_valid without sof), ACTIVE (accepting frame), DONE (frame complete; ignore in_valid without sof). sof&&in_valid from any state -> ACTIVE, pixel taken as (0,0), mode latched into mode_q.
- mode is sampled only on an accepted sof; changes mid-frame have no effect until the next sof.
- Counters: col increments per accepted pixel; col==IMG_W-1 wraps to 0 and increments row. After pixel (IMG_H-1, IMG_W-1) state -> DONE.
- sof mid-frame (ACTIVE) restarts the frame: counters restart at (0,0); stale line data only affects rows 0-1 and is never emitted.
- Window: accepted pixel at (r,c) with r>=2 and c>=2 completes the window centred at (r-1,c-1); only these produce output. Border rows/columns produce no output; (IMG_H-2)*(IMG_W-2) outputs per frame.
- Latency: triggering pixel accepted at edge k -> out_valid high after edge k+2 for exactly one cycle; out_x=c-1, out_y=r-1. Back-to-back inputs give back-to-back outputs; in_valid gaps propagate as out_valid gaps. No backpressure.
- Arithmetic: Gx=(p02+2p12+p22)-(p00+2p10+p20); Gy=(p20+2p21+p22)-(p00+2p01+p02); signed, DATA_W+3 bits, no overflow. Take absolute values, add for mode 2 (DATA_W+4 bits), shift right by SHIFT, saturate to 2^DATA_W-1. Mode 3 outputs p11 unmodified.
- frame_done asserted in the same cycle as out_valid for centre (IMG_H-2, IMG_W-2).
- Reset asserted mid-frame: outputs clear immediately (asynchronous), in-flight results discarded; state IDLE.
- in_valid with state DONE/IDLE and no sof: pixel dropped, no output.

Test Plan:
- Bench DATA_W=12, IMG_W=6, IMG_H=4, SHIFT=0. Flat frame of 0x100, mode 0 -> exactly 8 outputs, all 0x000, (x,y) raster from (1,1) to (4,2), frame_done on the 8th only.
- Vertical edge: cols 0-2 = 0x000, cols 3-5 = 0x0FF, mode 0 -> x=2,3 give 0x3FC, x=1,4 give 0x000; same frame, mode 1 -> all 0x000.
- Saturation: cols 0-2 = 0x000, cols 3-5 = 0xFFF, mode 2 -> x=2,3 give 0xFFF; SHIFT=2 rerun with 0x0FF edge -> 0x0FF.
- Gapped input: repeat edge test with in_valid dropped on random cycles -> identical output values, each out_valid exactly 2 cycles after its triggering pixel.
- Mode 3 with ramp pixel=16*r+c -> out_pixel=16*out_y+out_x; mode switched to 0 mid-frame -> still passthrough until next sof.
- rst_n low mid-frame -> outputs 0 with no clock edge; extra pixels without sof ignored; next sof frame is fully correct. Second sof mid-frame -> counters restart, 8 correct outputs follow.
